spi_master_link: RTL and testbench

- SPI mode-0 master that drives the 16-bit SPI slave link from the host side, full duplex, one word per SS_n frame.
- Accepts a parallel word through a valid/ready handshake, shifts it MSB-first on MOSI, and captures the slave's MISO word. Returns the captured word with a one-cycle valid pulse.
- Used as the link-test initiator: the bench or host logic sends N and expects N+1 back on the following frame.

---
 rtl/spi_master_link_if.sv | 23 ++
 rtl/spi_master_link.sv | 96 +++++++++
 tb/tb_spi_master_link.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_link_if.sv
// spi_master_link_if: host handshake and SPI pins of the link master
interface spi_master_link_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
    logic                  SCLK;
    logic                  MOSI;
    logic                  MISO;
    logic                  SS_n;
    modport master (
        input  tx_data, tx_valid, MISO,
        output tx_ready, rx_data, rx_valid, busy, SCLK, MOSI, SS_n
    );
    modport slave (
        output tx_data, tx_valid, MISO,
        input  tx_ready, rx_data, rx_valid, busy, SCLK, MOSI, SS_n
    );
endinterface

// File: rtl/spi_master_link.sv
// spi_master_link: SPI mode-0 full-duplex master, one word per SS_n frame
module spi_master_link #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4
) (
    input logic                clk,
    input logic                rst,
    spi_master_link_if.master  bus
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t                state_q;
    logic [CW-1:0]         div_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_WIDTH-1:0] tx_sh_q;
    logic [DATA_WIDTH-1:0] rx_sh_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  tx_ready_q;
    logic                  busy_q;
    logic                  rx_valid_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  ss_n_q;
    logic                  tick;
    assign tick         = div_q == CW'(CLK_DIV - 1);
    assign bus.tx_ready = tx_ready_q;
    assign bus.busy     = busy_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.SCLK     = sclk_q;
    assign bus.MOSI     = mosi_q;
    assign bus.SS_n     = ss_n_q;
    // Frame sequencer: every non-idle phase lasts whole half-periods of CLK_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q != IDLE) div_q <= tick ? '0 : div_q + 1'b1;
            case (state_q)
                IDLE: if (bus.tx_valid) begin
                    tx_sh_q    <= bus.tx_data;
                    mosi_q     <= bus.tx_data[DATA_WIDTH-1];
                    ss_n_q     <= 1'b0;
                    busy_q     <= 1'b1;
                    tx_ready_q <= 1'b0;
                    div_q      <= '0;
                    bit_q      <= '0;
                    state_q    <= SETUP;
                end
                SETUP: if (tick) begin
                    sclk_q  <= 1'b1;
                    rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], bus.MISO};
                    state_q <= SHIFT;
                end
                SHIFT: if (tick) begin
                    sclk_q <= !sclk_q;
                    if (!sclk_q) begin
                        rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], bus.MISO};
                    end else if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        state_q <= HOLD;
                    end else begin
                        bit_q   <= bit_q + 1'b1;
                        tx_sh_q <= tx_sh_q << 1;
                        mosi_q  <= tx_sh_q[DATA_WIDTH-2];
                    end
                end
                HOLD: if (tick) begin
                    ss_n_q     <= 1'b1;
                    rx_data_q  <= rx_sh_q;
                    rx_valid_q <= 1'b1;
                    mosi_q     <= 1'b0;
                    state_q    <= GAP;
                end
                GAP: if (tick) begin
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_link.sv
// tb_spi_master_link: directed scoreboard bench with loopback slave models
module tb_spi_master_link;
    typedef struct {
        logic [15:0] tx;
        logic [15:0] rx;
        int          cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t e;
    int   rxv_cyc[$];
    logic [15:0] s_next = 16'h1234;
    logic [15:0] m_next = 16'h1234;
    logic [15:0] sh_a = '0;
    logic [15:0] cap_a = '0;
    int   rises_a = 0;
    int   lo_a = 0;
    int   hi_a = 0;
    int   hi_gap = 0;
    logic pss_a = 1'b1;
    logic psclk_a = 1'b0;
    logic [7:0] sh_b = '0;
    logic [7:0] cap_b = '0;
    int   rises_b = 0;
    int   lrise_b = 0;
    logic pss_b = 1'b1;
    logic psclk_b = 1'b0;
    int   t;
    int   t2;
    int   tb0;
    int   n0;
    spi_master_link_if #(.DATA_WIDTH(16)) a ();
    spi_master_link_if #(.DATA_WIDTH(8))  b ();
    spi_master_link #(.DATA_WIDTH(16), .CLK_DIV(4)) dut_a (.clk(clk), .rst(rst), .bus(a.master));
    spi_master_link #(.DATA_WIDTH(8),  .CLK_DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(b.master));
    // Free-running clock and cycle count
    always #5 clk = ~clk;
    // Cycle number of the cycle that starts at each rising edge
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [15:0] d, input bit hold, output int ta);
        @(posedge clk); #1;
        a.tx_data  = d;
        a.tx_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a.tx_ready) break;
        end
        chk("accept_ready", a.tx_ready, 1'b1);
        ta = cyc;
        @(posedge clk); #1;
        if (!hold) a.tx_valid = 1'b0;
    endtask
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask
    // Stimulus, slave models and scoreboard all live in this one process
    initial begin
        rst = 1'b1;
        a.tx_valid = 1'b0;
        a.tx_data  = '0;
        a.MISO     = 1'b0;
        b.tx_valid = 1'b0;
        b.tx_data  = '0;
        b.MISO     = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (pss_a && !a.SS_n) begin
                    sh_a = s_next;
                    cap_a = '0;
                    rises_a = 0;
                    lo_a = 0;
                    hi_gap = hi_a;
                    if (sb.size() > 0) chk("ss_fall_cycle", cyc - sb[0].cyc, 1);
                end
                hi_a = a.SS_n ? hi_a + 1 : 0;
                if (!a.SS_n) lo_a++;
                if (!psclk_a && a.SCLK) begin
                    cap_a = {cap_a[14:0], a.MOSI};
                    rises_a++;
                end
                if (psclk_a && !a.SCLK && !a.SS_n) sh_a = sh_a << 1;
                a.MISO = sh_a[15];
                if (!pss_a && a.SS_n && rises_a == 16) s_next = cap_a + 16'd1;
                if (a.rx_valid) begin
                    if (sb.size() == 0) begin
                        chk("rxv_spurious", a.rx_valid, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("rx_data", a.rx_data, e.rx);
                        chk("mosi_word", cap_a, e.tx);
                        chk("sclk_rises", rises_a, 16);
                        chk("ss_low_cycles", lo_a, 132);
                        chk("rxv_latency", cyc - e.cyc, 133);
                        m_next = e.tx + 16'd1;
                    end
                    rxv_cyc.push_back(cyc);
                end
                if (rst) sb.delete();
                else if (a.tx_valid && a.tx_ready) sb.push_back('{a.tx_data, m_next, cyc});
                pss_a = a.SS_n;
                psclk_a = a.SCLK;
                if (pss_b && !b.SS_n) begin
                    sh_b = 8'hC3;
                    cap_b = '0;
                    rises_b = 0;
                end
                if (!psclk_b && b.SCLK) begin
                    if (rises_b > 0) chk("b_sclk_period", cyc - lrise_b, 2);
                    lrise_b = cyc;
                    cap_b = {cap_b[6:0], b.MOSI};
                    rises_b++;
                end
                if (psclk_b && !b.SCLK && !b.SS_n) sh_b = sh_b << 1;
                b.MISO = sh_b[7];
                pss_b = b.SS_n;
                psclk_b = b.SCLK;
            end
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ss_n", a.SS_n, 1'b1);
        chk("rst_sclk", a.SCLK, 1'b0);
        chk("rst_mosi", a.MOSI, 1'b0);
        chk("rst_tx_ready", a.tx_ready, 1'b1);
        chk("rst_busy", a.busy, 1'b0);
        chk("rst_rx_valid", a.rx_valid, 1'b0);
        chk("rst_rx_data", a.rx_data, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        send(16'hA55A, 1'b0, t);
        wait_until(t + 132);
        chk("t1_ss_low_end", a.SS_n, 1'b0);
        wait_until(t + 133);
        chk("t1_rx_valid", a.rx_valid, 1'b1);
        chk("t1_rx_data", a.rx_data, 16'h1234);
        chk("t1_ss_high", a.SS_n, 1'b1);
        wait_until(t + 136);
        chk("t1_ready_early", a.tx_ready, 1'b0);
        wait_until(t + 137);
        chk("t1_ready", a.tx_ready, 1'b1);
        chk("t1_busy", a.busy, 1'b0);
        send(16'h0005, 1'b0, t);
        send(16'h0000, 1'b0, t2);
        chk("link_accept_spacing", t2 - t, 137);
        wait_until(t2 + 2);
        chk("link_ss_gap", hi_gap, 5);
        wait_until(t2 + 134);
        chk("link_rx_data", a.rx_data, 16'h0006);
        n0 = rxv_cyc.size();
        send(16'hFFFF, 1'b1, t);
        send(16'h0000, 1'b1, t);
        send(16'h8001, 1'b0, t);
        wait_until(t + 140);
        chk("stream_frames", rxv_cyc.size(), n0 + 3);
        if (rxv_cyc.size() == n0 + 3) begin
            chk("stream_spacing1", rxv_cyc[n0+1] - rxv_cyc[n0], 137);
            chk("stream_spacing2", rxv_cyc[n0+2] - rxv_cyc[n0+1], 137);
        end
        n0 = rxv_cyc.size();
        send(16'h4321, 1'b0, t);
        wait_until(t + 49);
        @(posedge clk); #1;
        a.tx_data  = 16'hDEAD;
        a.tx_valid = 1'b1;
        @(negedge clk);
        chk("busy_busy", a.busy, 1'b1);
        chk("busy_ready", a.tx_ready, 1'b0);
        @(posedge clk); #1;
        a.tx_valid = 1'b0;
        wait_until(t + 200);
        chk("busy_frames", rxv_cyc.size(), n0 + 1);
        chk("busy_sb_empty", sb.size(), 0);
        chk("busy_rx_data", a.rx_data, 16'h8002);
        n0 = rxv_cyc.size();
        send(16'h1357, 1'b0, t);
        wait_until(t + 59);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_ss_n", a.SS_n, 1'b1);
        chk("mrst_sclk", a.SCLK, 1'b0);
        chk("mrst_mosi", a.MOSI, 1'b0);
        chk("mrst_tx_ready", a.tx_ready, 1'b1);
        chk("mrst_busy", a.busy, 1'b0);
        chk("mrst_rx_data", a.rx_data, 16'h0000);
        wait_until(t + 250);
        chk("mrst_no_rxv", rxv_cyc.size(), n0);
        send(16'h00FF, 1'b0, t);
        wait_until(t + 134);
        chk("mrst_next_rx", a.rx_data, 16'h4322);
        chk("mrst_next_frames", rxv_cyc.size(), n0 + 1);
        @(posedge clk); #1;
        b.tx_data  = 8'h3C;
        b.tx_valid = 1'b1;
        @(negedge clk);
        chk("b_ready", b.tx_ready, 1'b1);
        tb0 = cyc;
        @(posedge clk); #1;
        b.tx_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b.rx_valid) break;
        end
        chk("b_rx_valid", b.rx_valid, 1'b1);
        chk("b_rxv_latency", cyc - tb0, 18);
        chk("b_rx_data", b.rx_data, 8'hC3);
        chk("b_mosi_word", cap_b, 8'h3C);
        chk("b_sclk_rises", rises_b, 8);
        @(negedge clk);
        chk("b_rxv_pulse", b.rx_valid, 1'b0);
        chk("sb_empty_end", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
